// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free, period-boundary config updates.
// Optional phase-alignment input `sync` is built only when CLKGEN_SYNC_EN is defined.
module clk_div_multi #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [WIDTH-1:0]    cfg_high,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] out_clk,
  output logic [CHANNELS-1:0] tick
`ifdef CLKGEN_SYNC_EN
  ,
  input  logic                sync
`endif
);

  localparam logic [WIDTH-1:0] RST_N = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_H = (DEFAULT_DIV / 2 < 1) ? WIDTH'(1) : WIDTH'(DEFAULT_DIV / 2);

  logic [WIDTH-1:0]    na_q  [CHANNELS];
  logic [WIDTH-1:0]    na_d  [CHANNELS];
  logic [WIDTH-1:0]    ha_q  [CHANNELS];
  logic [WIDTH-1:0]    ha_d  [CHANNELS];
  logic [WIDTH-1:0]    ns_q  [CHANNELS];
  logic [WIDTH-1:0]    ns_d  [CHANNELS];
  logic [WIDTH-1:0]    hs_q  [CHANNELS];
  logic [WIDTH-1:0]    hs_d  [CHANNELS];
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] en_q;
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic                err_q, err_d;

  logic [7:0]       pend_pad;
  logic             ch_ok;
  logic             xfer;
  logic             sync_w;
  logic [WIDTH-1:0] n_cl, h_cl;

`ifdef CLKGEN_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range channels are always ready so a bad request cannot stall the port.
  always_comb begin
    pend_pad                 = '0;
    pend_pad[CHANNELS-1:0]   = pend_q;
    ch_ok                    = (32'(cfg_ch) < CHANNELS);
    cfg_ready                = ch_ok ? ~pend_pad[cfg_ch] : 1'b1;
    xfer                     = cfg_valid & cfg_ready & ch_ok;
    err_d                    = cfg_valid & cfg_ready & ~ch_ok;
  end

  always_comb begin
    n_cl = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;
    h_cl = (cfg_high == '0) ? WIDTH'(1) : cfg_high;
    if (h_cl > n_cl - WIDTH'(1)) h_cl = n_cl - WIDTH'(1);
  end

  always_comb begin : next_state
    logic acc, restart;
    acc     = 1'b0;
    restart = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      na_d[c]   = na_q[c];
      ha_d[c]   = ha_q[c];
      ns_d[c]   = ns_q[c];
      hs_d[c]   = hs_q[c];
      cnt_d[c]  = cnt_q[c];
      pend_d[c] = pend_q[c];
      out_d[c]  = 1'b0;
      tick_d[c] = 1'b0;
      acc       = xfer && (32'(cfg_ch) == c);
      restart   = sync_w || !en_q[c] || (cnt_q[c] == na_q[c] - WIDTH'(1));
      if (!en[c]) begin
        cnt_d[c] = '0;
        if (pend_q[c]) begin
          na_d[c]   = ns_q[c];
          ha_d[c]   = hs_q[c];
          pend_d[c] = 1'b0;
        end
        if (acc) begin
          na_d[c] = n_cl;
          ha_d[c] = h_cl;
          ns_d[c] = n_cl;
          hs_d[c] = h_cl;
        end
      end else begin
        // Accept is only possible with pending clear, so it never races the apply below.
        if (restart) begin
          cnt_d[c]  = '0;
          tick_d[c] = 1'b1;
          if (pend_q[c]) begin
            na_d[c]   = ns_q[c];
            ha_d[c]   = hs_q[c];
            pend_d[c] = 1'b0;
          end
        end else begin
          cnt_d[c] = cnt_q[c] + WIDTH'(1);
        end
        if (acc) begin
          ns_d[c]   = n_cl;
          hs_d[c]   = h_cl;
          pend_d[c] = 1'b1;
        end
        out_d[c] = (cnt_d[c] < ha_d[c]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        na_q[c]  <= RST_N;
        ha_q[c]  <= RST_H;
        ns_q[c]  <= RST_N;
        hs_q[c]  <= RST_H;
        cnt_q[c] <= '0;
      end
      pend_q <= '0;
      en_q   <= '0;
      out_q  <= '0;
      tick_q <= '0;
      err_q  <= 1'b0;
    end else begin
      na_q   <= na_d;
      ha_q   <= ha_d;
      ns_q   <= ns_d;
      hs_q   <= hs_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      en_q   <= en;
      out_q  <= out_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign out_clk = out_q;
  assign tick    = tick_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: constant vector table, period measurements,
// and randomized traffic against a phase-based reference model.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic       cfg_err;
  logic [1:0] out_clk;
  logic [1:0] tick;
  logic       sync;
  logic       rdy;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .CHANNELS    (2),
    .WIDTH       (8),
    .DEFAULT_DIV (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_err   (cfg_err),
    .out_clk   (out_clk),
    .tick      (tick)
`ifdef CLKGEN_SYNC_EN
    ,
    .sync      (sync)
`endif
  );

  // Reference model: each channel is described by its phase within the current period.
  int   m_n[2], m_h[2], m_sn[2], m_sh[2], m_p[2];
  bit   m_pend[2], m_run[2];
  logic [1:0] m_out, m_tick;
  logic m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 10; m_h[i] = 5; m_sn[i] = 10; m_sh[i] = 5;
      m_p[i] = 0; m_pend[i] = 0; m_run[i] = 0;
    end
    m_out = '0; m_tick = '0; m_err = 1'b0;
  endfunction

  function automatic void model_edge(input logic [1:0] e, input logic x, input logic [2:0] ch,
                                     input logic [7:0] d, input logic [7:0] h, input logic s);
    int cn, chh;
    cn  = (int'(d) < 2) ? 2 : int'(d);
    chh = (int'(h) < 1) ? 1 : int'(h);
    if (chh > cn - 1) chh = cn - 1;
    m_err = x && (ch >= 3'd2);
    for (int c = 0; c < 2; c++) begin
      bit acc;
      acc = x && (int'(ch) == c);
      if (!e[c]) begin
        if (m_pend[c]) begin m_n[c] = m_sn[c]; m_h[c] = m_sh[c]; m_pend[c] = 0; end
        if (acc) begin m_n[c] = cn; m_h[c] = chh; m_sn[c] = cn; m_sh[c] = chh; end
        m_p[c] = 0; m_out[c] = 1'b0; m_tick[c] = 1'b0;
      end else begin
        if (s || !m_run[c] || m_p[c] + 1 >= m_n[c]) begin
          m_p[c] = 0;
          if (m_pend[c]) begin m_n[c] = m_sn[c]; m_h[c] = m_sh[c]; m_pend[c] = 0; end
        end else begin
          m_p[c] = m_p[c] + 1;
        end
        if (acc) begin m_sn[c] = cn; m_sh[c] = chh; m_pend[c] = 1; end
        m_tick[c] = (m_p[c] == 0);
        m_out[c]  = (m_p[c] < m_h[c]);
      end
      m_run[c] = e[c];
    end
  endfunction

  // One clock cycle: drive at the falling edge, check ready, clock, check registered outputs.
  task automatic step(input logic [1:0] e, input logic v, input logic [2:0] ch, input logic [7:0] d,
                      input logic [7:0] h, input logic s, output logic rdy_o);
    logic exp_rdy;
    en = e; cfg_valid = v; cfg_ch = ch; cfg_div = d; cfg_high = h; sync = s;
    #1;
    exp_rdy = (ch >= 3'd2) ? 1'b1 : !m_pend[ch[0]];
    rdy_o = cfg_ready;
    check("cfg_ready", {31'd0, cfg_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    model_edge(e, v && exp_rdy, ch, d, h, s);
    @(negedge clk);
    check("out_clk", {30'd0, out_clk}, {30'd0, m_out});
    check("tick", {30'd0, tick}, {30'd0, m_tick});
    check("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
  endtask

  // Wait for a tick on channel c, then measure the following full period and its high time.
  task automatic measure(input int c, input int ep, input int eh, input logic [1:0] e);
    int waited, per, hi;
    bit found;
    waited = 0; found = 0;
    while (!found && waited < 64) begin
      step(e, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, rdy);
      waited++;
      found = tick[c];
    end
    check("measure_first_tick", {31'd0, found}, 32'd1);
    per = 1; hi = int'(out_clk[c]); found = 0;
    while (!found && per < 64) begin
      step(e, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, rdy);
      found = tick[c];
      if (!found) begin per++; hi += int'(out_clk[c]); end
    end
    check("measure_period", per, ep);
    check("measure_high", hi, eh);
  endtask

  typedef struct {
    logic [1:0] en;
    logic       v;
    logic [2:0] ch;
    logic [7:0] d, h;
    logic [1:0] eo, et;
    logic       er, ee;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [2:0] ch, input logic [1:0] eo,
                              input logic [1:0] et, input logic ee);
    vec_t r;
    r.en = 2'b01; r.v = v; r.ch = ch; r.d = 8'd3; r.h = 8'd1;
    r.eo = eo; r.et = et; r.er = 1'b1; r.ee = ee;
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    for (int i = 0; i < 12; i++)
      tbl[i] = mk(1'b0, 3'd0, {1'b0, (i % 10) < 5}, {1'b0, (i % 10) == 0}, 1'b0);
    tbl[12] = mk(1'b1, 3'd5, 2'b01, 2'b00, 1'b1);
    tbl[13] = mk(1'b0, 3'd0, 2'b01, 2'b00, 1'b0);
    tbl[14] = mk(1'b0, 3'd0, 2'b01, 2'b00, 1'b0);
    tbl[15] = mk(1'b0, 3'd0, 2'b00, 2'b00, 1'b0);

    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0; sync = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_clk", {30'd0, out_clk}, 32'd0);
    check("rst_tick", {30'd0, tick}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b0;

    // Free run of channel 0 at the default divider, plus an out-of-range transfer.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].h, 1'b0, rdy);
      check("tbl_ready", {31'd0, rdy}, {31'd0, tbl[i].er});
      check("tbl_out_clk", {30'd0, out_clk}, {30'd0, tbl[i].eo});
      check("tbl_tick", {30'd0, tick}, {30'd0, tbl[i].et});
      check("tbl_cfg_err", {31'd0, cfg_err}, {31'd0, tbl[i].ee});
    end

    // Mid-period rewrite of channel 0; channel 1 (disabled) still accepts in the window.
    step(2'b01, 1'b1, 3'd0, 8'd4, 8'd1, 1'b0, rdy);
    check("wr0_ready", {31'd0, rdy}, 32'd1);
    step(2'b01, 1'b1, 3'd1, 8'd0, 8'd9, 1'b0, rdy);
    check("wr1_ready_in_window", {31'd0, rdy}, 32'd1);
    step(2'b01, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, rdy);
    check("ch0_ready_blocked", {31'd0, rdy}, 32'd0);
    check("ch1_idle_out", {31'd0, out_clk[1]}, 32'd0);
    measure(0, 4, 1, 2'b01);
    step(2'b01, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, rdy);
    check("ch0_ready_after_wrap", {31'd0, rdy}, 32'd1);

    // Clamping on channel 1.
    measure(1, 2, 1, 2'b11);
    step(2'b11, 1'b1, 3'd1, 8'd6, 8'd0, 1'b0, rdy);
    measure(1, 6, 1, 2'b11);

    // Reset mid-cycle with a pending write: the write must be lost.
    step(2'b11, 1'b1, 3'd0, 8'd7, 8'd3, 1'b0, rdy);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_clk", {30'd0, out_clk}, 32'd0);
    check("midrst_tick", {30'd0, tick}, 32'd0);
    check("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    measure(0, 10, 5, 2'b01);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] e;
      logic       v, s;
      logic [2:0] ch;
      e[0] = ($urandom_range(0, 9) != 0);
      e[1] = ($urandom_range(0, 9) != 0);
      v    = ($urandom_range(0, 2) == 0);
      ch   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      s    = 1'b0;
`ifdef CLKGEN_SYNC_EN
      s    = ($urandom_range(0, 19) == 0);
`endif
      step(e, v, ch, 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), s, rdy);
    end

`ifdef CLKGEN_SYNC_EN
    // Phase alignment of N=6 and N=9 channels.
    step(2'b00, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, rdy);
    step(2'b00, 1'b1, 3'd0, 8'd6, 8'd3, 1'b0, rdy);
    step(2'b00, 1'b1, 3'd1, 8'd9, 8'd4, 1'b0, rdy);
    repeat (4) step(2'b01, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, rdy);
    repeat (3) step(2'b11, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, rdy);
    step(2'b11, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, rdy);
    check("sync_tick", {30'd0, tick}, 32'd3);
    repeat (17) step(2'b11, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, rdy);
    step(2'b11, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, rdy);
    check("sync_tick_18", {30'd0, tick}, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
